// File: rtl/rv_pkg.sv
// RV32I opcode/funct3 constants and an encoding-legality helper shared by the ID stage.
package rv_pkg;

   localparam int RV_XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // funct3/funct7 legality for the supported subset; opcode validity comes from the imm generator
   function automatic logic rv_fields_legal(input logic [31:0] inst);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc = inst[6:0];
      f3  = inst[14:12];
      f7  = inst[31:25];
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL: rv_fields_legal = 1'b1;
         OPC_JALR:   rv_fields_legal = (f3 == F3_ADD);
         OPC_BRANCH: rv_fields_legal = (f3 != 3'b010) && (f3 != 3'b011);
         OPC_LOAD:   rv_fields_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010)
                                    || (f3 == 3'b100) || (f3 == 3'b101);
         OPC_STORE:  rv_fields_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
         OPC_OP_IMM: begin
            if (f3 == F3_SLL)      rv_fields_legal = (f7 == F7_BASE);
            else if (f3 == F3_SRL) rv_fields_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            else                   rv_fields_legal = 1'b1;
         end
         OPC_OP: rv_fields_legal = (f7 == F7_BASE)
                                || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
         default: rv_fields_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_decode_if.sv
// ID/EX register bundle toward EX; master = decode stage, slave = EX stage.
interface id_ex_decode_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              ex_ready_i;
   logic              ex_valid_o;
   logic [XLEN-1:0]   ex_pc_o;
   logic [6:0]        ex_aluop_o;
   logic [2:0]        ex_alusel_o;
   logic              ex_sub_sra_o;
   logic [XLEN-1:0]   ex_reg1_o;
   logic [XLEN-1:0]   ex_reg2_o;
   logic [XLEN-1:0]   ex_imm_o;
   logic [REG_AW-1:0] ex_wd_o;
   logic              ex_wreg_o;
   logic              ex_is_load_o;
   logic              ex_mem_we_o;

   modport master (
      input  ex_ready_i,
      output ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_sub_sra_o,
             ex_reg1_o, ex_reg2_o, ex_imm_o, ex_wd_o, ex_wreg_o,
             ex_is_load_o, ex_mem_we_o
   );

   modport slave (
      output ex_ready_i,
      input  ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_sub_sra_o,
             ex_reg1_o, ex_reg2_o, ex_imm_o, ex_wd_o, ex_wreg_o,
             ex_is_load_o, ex_mem_we_o
   );
endinterface

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator; o_fmt_valid flags opcodes with a known format.
module rv_imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_inst,
   output logic [XLEN-1:0] o_imm,
   output logic            o_fmt_valid
);

   logic signed [31:0] w_imm32;

   always_comb begin
      w_imm32     = '0;
      o_fmt_valid = 1'b1;
      case (i_inst[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
         OPC_STORE:
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         OPC_BRANCH:
            w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            w_imm32 = {i_inst[31:12], 12'b0};
         OPC_JAL:
            w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
         OPC_OP:
            w_imm32 = '0;
         default:
            o_fmt_valid = 1'b0;
      endcase
   end

   assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/id_ex_decode.sv
// RV32I decoder fused with the ID/EX register: priority forwarding, load-use interlock,
// valid/ready backpressure and flush. EX sees registered values only.
module id_ex_decode
   import rv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [XLEN-1:0]           pc_i,
   input  logic [31:0]               inst_i,
   input  logic                      inst_valid_i,
   output logic                      id_ready_o,
   output logic                      reg1_read_o,
   output logic                      reg2_read_o,
   output logic [REG_AW-1:0]         reg1_addr_o,
   output logic [REG_AW-1:0]         reg2_addr_o,
   input  logic [XLEN-1:0]           reg1_data_i,
   input  logic [XLEN-1:0]           reg2_data_i,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
   input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata_i,
   input  logic                      flush_i,
   output logic                      illegal_o,
   id_ex_decode_if.master            ex_if
);

   logic [6:0]        w_opc;
   logic [2:0]        w_f3;
   logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
   logic              w_rd1, w_rd2, w_wreg, w_is_load, w_mem_we, w_sub_sra;
   logic [XLEN-1:0]   w_imm;
   logic              w_fmt_valid, w_legal;
   logic [XLEN-1:0]   w_op1, w_op2;
   logic              w_hazard, w_ready, w_accept;

   logic              r_valid, r_sub_sra, r_wreg, r_is_load, r_mem_we, r_illegal;
   logic [XLEN-1:0]   r_pc, r_reg1, r_reg2, r_imm;
   logic [6:0]        r_aluop;
   logic [2:0]        r_alusel;
   logic [REG_AW-1:0] r_wd;

   assign w_opc = inst_i[6:0];
   assign w_f3  = inst_i[14:12];
   assign w_rs1 = inst_i[15 +: REG_AW];
   assign w_rs2 = inst_i[20 +: REG_AW];
   assign w_rd  = inst_i[7 +: REG_AW];

   rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_inst      (inst_i),
      .o_imm       (w_imm),
      .o_fmt_valid (w_fmt_valid)
   );

   assign w_legal = w_fmt_valid & rv_fields_legal(inst_i);

   always_comb begin
      w_rd1     = 1'b0;
      w_rd2     = 1'b0;
      w_is_load = 1'b0;
      w_mem_we  = 1'b0;
      w_sub_sra = 1'b0;
      case (w_opc)
         OPC_JALR, OPC_LOAD: w_rd1 = 1'b1;
         OPC_BRANCH, OPC_STORE: begin
            w_rd1 = 1'b1;
            w_rd2 = 1'b1;
         end
         OPC_OP_IMM: begin
            w_rd1     = 1'b1;
            w_sub_sra = (w_f3 == F3_SRL) & inst_i[30];
         end
         OPC_OP: begin
            w_rd1     = 1'b1;
            w_rd2     = 1'b1;
            w_sub_sra = inst_i[30];
         end
         default: ;
      endcase
      w_is_load = (w_opc == OPC_LOAD);
      w_mem_we  = (w_opc == OPC_STORE);
      w_rd1     = w_rd1 & inst_valid_i;
      w_rd2     = w_rd2 & inst_valid_i;
   end

   assign w_wreg = (w_opc != OPC_BRANCH) && (w_opc != OPC_STORE) && (w_rd != '0);

   // Forwarding chain built from the oldest source up, so index 0 (youngest) overrides all others
   logic [XLEN-1:0] w_chain1 [NUM_FWD+1];
   logic [XLEN-1:0] w_chain2 [NUM_FWD+1];

   assign w_chain1[NUM_FWD] = reg1_data_i;
   assign w_chain2[NUM_FWD] = reg2_data_i;

   for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
      assign w_chain1[k] = (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == w_rs1))
                           ? fwd_wdata_i[k*XLEN +: XLEN] : w_chain1[k+1];
      assign w_chain2[k] = (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == w_rs2))
                           ? fwd_wdata_i[k*XLEN +: XLEN] : w_chain2[k+1];
   end

   assign w_op1 = (w_rd1 && (w_rs1 != '0)) ? w_chain1[0] : '0;
   assign w_op2 = (w_rd2 && (w_rs2 != '0)) ? w_chain2[0] : '0;

   assign w_hazard = r_valid & r_is_load & (r_wd != '0)
                   & ((w_rd1 & (w_rs1 == r_wd)) | (w_rd2 & (w_rs2 == r_wd)));

   assign w_ready  = flush_i | (ex_if.ex_ready_i & ~w_hazard);
   assign w_accept = inst_valid_i & w_ready & ex_if.ex_ready_i & ~flush_i;

   assign id_ready_o  = rst_n & w_ready;
   assign reg1_read_o = rst_n & w_rd1;
   assign reg2_read_o = rst_n & w_rd2;
   assign reg1_addr_o = rst_n ? w_rs1 : '0;
   assign reg2_addr_o = rst_n ? w_rs2 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_aluop   <= '0;
         r_alusel  <= '0;
         r_sub_sra <= 1'b0;
         r_reg1    <= '0;
         r_reg2    <= '0;
         r_imm     <= '0;
         r_wd      <= '0;
         r_wreg    <= 1'b0;
         r_is_load <= 1'b0;
         r_mem_we  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         if (flush_i) begin
            r_valid   <= 1'b0;
            r_wreg    <= 1'b0;
            r_is_load <= 1'b0;
            r_mem_we  <= 1'b0;
         end else if (ex_if.ex_ready_i) begin
            if (w_accept && w_legal) begin
               r_valid   <= 1'b1;
               r_pc      <= pc_i;
               r_aluop   <= w_opc;
               r_alusel  <= w_f3;
               r_sub_sra <= w_sub_sra;
               r_reg1    <= w_op1;
               r_reg2    <= w_op2;
               r_imm     <= w_imm;
               r_wd      <= w_rd;
               r_wreg    <= w_wreg;
               r_is_load <= w_is_load;
               r_mem_we  <= w_mem_we;
            end else begin
               // bubble: load-use stall, illegal encoding or nothing offered
               r_valid   <= 1'b0;
               r_wreg    <= 1'b0;
               r_is_load <= 1'b0;
               r_mem_we  <= 1'b0;
               r_illegal <= w_accept;
            end
         end
      end
   end

   assign ex_if.ex_valid_o   = r_valid;
   assign ex_if.ex_pc_o      = r_pc;
   assign ex_if.ex_aluop_o   = r_aluop;
   assign ex_if.ex_alusel_o  = r_alusel;
   assign ex_if.ex_sub_sra_o = r_sub_sra;
   assign ex_if.ex_reg1_o    = r_reg1;
   assign ex_if.ex_reg2_o    = r_reg2;
   assign ex_if.ex_imm_o     = r_imm;
   assign ex_if.ex_wd_o      = r_wd;
   assign ex_if.ex_wreg_o    = r_wreg;
   assign ex_if.ex_is_load_o = r_is_load;
   assign ex_if.ex_mem_we_o  = r_mem_we;
   assign illegal_o          = r_illegal;

endmodule
